// File: rtl/seq_decoder_2to4.sv
// Registered 2-to-4 decoder with a one-entry pending word; Y follows an accept by one clock and holds HOLD_CYCLES clocks.
// Backpressure: in_ready is low while the pending register is full; V=0 words are dropped and counted (saturating).
module seq_decoder_2to4 #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       A,
  input  logic       B,
  input  logic       V,
  output logic [3:0] Y,
  output logic       Y_valid,
  output logic [7:0] null_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic             r_pend_full, w_pend_full_nxt;
  logic [2:0]       r_pend, w_pend_nxt;       // {A,B,V}
  logic [3:0]       r_y, w_y_nxt;
  logic             r_y_valid, w_y_valid_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_null_cnt, w_null_nxt;

  logic             w_accept;
  logic [3:0]       w_pend_dec;
  logic [7:0]       w_null_inc;

  assign in_ready   = ~r_pend_full;
  assign w_accept   = in_valid & ~r_pend_full;
  assign w_pend_dec = 4'b0001 << r_pend[2:1];
  assign w_null_inc = (r_null_cnt == 8'hFF) ? r_null_cnt : r_null_cnt + 8'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_full_nxt = r_pend_full;
    w_pend_nxt      = r_pend;
    w_y_nxt         = r_y;
    w_y_valid_nxt   = r_y_valid;
    w_cnt_nxt       = r_cnt;
    w_null_nxt      = r_null_cnt;

    case (r_state)
      S_IDLE: begin
        if (r_pend_full) begin
          w_pend_full_nxt = 1'b0;
          if (r_pend[0]) begin
            w_y_nxt       = w_pend_dec;
            w_y_valid_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_HOLD;
          end else begin
            w_null_nxt = w_null_inc;
          end
        end
      end
      S_HOLD: begin
        if (r_cnt < L_CNT_LAST) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (r_pend_full && r_pend[0]) begin
          // Back-to-back pattern: reload without a Y_valid bubble.
          w_y_nxt         = w_pend_dec;
          w_cnt_nxt       = '0;
          w_pend_full_nxt = 1'b0;
        end else begin
          if (r_pend_full) begin
            w_pend_full_nxt = 1'b0;
            w_null_nxt      = w_null_inc;
          end
          w_y_nxt       = 4'b0000;
          w_y_valid_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Accept and drain never coincide: accept needs the pending slot empty.
    if (w_accept) begin
      w_pend_nxt      = {A, B, V};
      w_pend_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pend_full <= 1'b0;
      r_pend      <= 3'b000;
      r_y         <= 4'b0000;
      r_y_valid   <= 1'b0;
      r_cnt       <= '0;
      r_null_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_pend      <= w_pend_nxt;
      r_y         <= w_y_nxt;
      r_y_valid   <= w_y_valid_nxt;
      r_cnt       <= w_cnt_nxt;
      r_null_cnt  <= w_null_nxt;
    end
  end

  assign Y        = r_y;
  assign Y_valid  = r_y_valid;
  assign null_cnt = r_null_cnt;

endmodule

// File: tb/tb_seq_decoder_2to4.sv
// Scoreboarded bench for two decoder instances (HOLD_CYCLES=4 and 1): stimulus pushes expected
// patterns with their start cycle, a negedge monitor pops and checks every output segment.
module tb_seq_decoder_2to4;

  localparam int HOLD0 = 4;
  localparam int HOLD1 = 1;

  typedef struct {
    logic [3:0] pat;
    int         start;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      in_valid, in_a, in_b, in_v, rdy, yv;
  logic [1:0][3:0] y;
  logic [1:0][7:0] nc;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   last_start[2];
  int   null_model[2];
  int   seg_len[2];
  logic [3:0] seg_pat[2];
  bit   prev_vld[2];

  seq_decoder_2to4 #(.HOLD_CYCLES(HOLD0), .CNT_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy[0]),
    .A(in_a[0]), .B(in_b[0]), .V(in_v[0]),
    .Y(y[0]), .Y_valid(yv[0]), .null_cnt(nc[0])
  );

  seq_decoder_2to4 #(.HOLD_CYCLES(HOLD1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy[1]),
    .A(in_a[1]), .B(in_b[1]), .V(in_v[1]),
    .Y(y[1]), .Y_valid(yv[1]), .null_cnt(nc[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  function automatic int hold(input int id);
    return (id == 0) ? HOLD0 : HOLD1;
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int id);
    return (id == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      last_start[i] = -1000;
      null_model[i] = 0;
    end
  endtask

  // Reference: pattern shows from accept+1, but never before the previous pattern's hold ends.
  task automatic model_accept(input int id, input logic a, input logic b, input logic v, input int acc);
    exp_t e;
    if (v) begin
      e.pat   = 4'b0001 << {a, b};
      e.start = acc + 1;
      if (last_start[id] + hold(id) > e.start) e.start = last_start[id] + hold(id);
      last_start[id] = e.start;
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
    end else if (null_model[id] < 255) begin
      null_model[id]++;
    end
  endtask

  task automatic send(input int id, input logic a, input logic b, input logic v, output int acc);
    bit ok = 1'b0;
    acc = -1;
    in_a[id] = a;
    in_b[id] = b;
    in_v[id] = v;
    in_valid[id] = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (rdy[id]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      fail_now("send_accept");
      in_valid[id] = 1'b0;
    end else begin
      acc = cyc + 1;
      model_accept(id, a, b, v, acc);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int id);
    bit ok = 1'b0;
    in_valid[id] = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rdy[id] && !yv[id] && qsize(id) == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("wait_idle");
    chk("null_cnt", nc[id], null_model[id]);
  endtask

  task automatic mon_step(input int id);
    exp_t e;
    if (!rst_n) begin
      seg_len[id]  = 0;
      prev_vld[id] = 1'b0;
      return;
    end
    if (yv[id]) begin
      if (!prev_vld[id] || seg_len[id] == hold(id)) begin
        if (qsize(id) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: inst %0d Y=%b with no pattern expected (cycle %0d)", id, y[id], cyc);
          seg_pat[id] = 4'b0000;
        end else begin
          e = qpop(id);
          chk("seg_pattern", y[id], e.pat);
          chk("seg_start_cycle", cyc, e.start);
          seg_pat[id] = e.pat;
        end
        seg_len[id] = 1;
      end else begin
        chk("hold_stable", y[id], seg_pat[id]);
        seg_len[id]++;
      end
    end else begin
      chk("idle_y_zero", y[id], 4'b0000);
      if (prev_vld[id]) chk("seg_length", seg_len[id], hold(id));
      seg_len[id] = 0;
    end
    prev_vld[id] = yv[id];
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon_step(i);
  end

  initial begin
    int acc;
    int accs[4];
    rst_n    = 1'b1;
    in_valid = 2'b00;
    in_a     = 2'b00;
    in_b     = 2'b00;
    in_v     = 2'b00;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", rdy[i], 1'b1);
      chk("rst_y_valid", yv[i], 1'b0);
      chk("rst_y", y[i], 4'b0000);
      chk("rst_null_cnt", nc[i], 8'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // single pattern, then back-to-back with valid held
    send(0, 1'b1, 1'b0, 1'b1, acc);
    wait_idle(0);
    send(0, 1'b1, 1'b1, 1'b1, acc);
    send(0, 1'b0, 1'b1, 1'b1, acc);
    chk("in_ready_low_pending", rdy[0], 1'b0);
    wait_idle(0);

    // null word queued behind a live pattern
    send(0, 1'b0, 1'b0, 1'b1, acc);
    send(0, 1'b0, 1'b0, 1'b0, acc);
    wait_idle(0);

    // null words while idle, up to saturation
    send(0, 1'b1, 1'b1, 1'b0, acc);
    wait_idle(0);
    for (int i = 0; i < 299; i++) send(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, acc);
    wait_idle(0);
    chk("null_cnt_saturated", nc[0], 8'd255);

    // async reset mid-hold with a word pending
    send(0, 1'b1, 1'b1, 1'b0, acc);
    wait_idle(0);
    send(0, 1'b1, 1'b1, 1'b1, acc);
    send(0, 1'b0, 1'b0, 1'b1, acc);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 2'b00;
    model_reset();
    #1;
    chk("arst_y", y[0], 4'b0000);
    chk("arst_y_valid", yv[0], 1'b0);
    chk("arst_in_ready", rdy[0], 1'b1);
    chk("arst_null_cnt", nc[0], 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_no_stale", yv[0], 1'b0);
    end

    // HOLD_CYCLES=1 streaming
    for (int i = 0; i < 4; i++) send(1, 1'(i >> 1), 1'(i), 1'b1, accs[i]);
    for (int i = 1; i < 4; i++) chk("hold1_accept_gap", accs[i] - accs[i-1], 2);
    wait_idle(1);

    // randomized traffic on both instances
    for (int r = 0; r < 160; r++) begin
      int id = int'($urandom_range(0, 1));
      in_valid[1 - id] = 1'b0;
      send(id, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
      if ($urandom_range(0, 3) == 0) begin
        in_valid[id] = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
    end
    wait_idle(0);
    wait_idle(1);
    chk("queue0_drained", qsize(0), 0);
    chk("queue1_drained", qsize(1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
